// File: rtl/cvmcu_dbg_req_ctrl.sv
// Debug halt/resume request controller for a CV32-class core, plus a debug-aware system timer.
// Sequences debug_req_o against the core's stoptimer_o handshake and times out stalled requests.
module cvmcu_dbg_req_ctrl #(
  parameter int unsigned TIMER_W     = 32,
  parameter int unsigned REQ_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               halt_req_i,
  input  logic               resume_req_i,
  output logic               debug_req_o,
  input  logic               stoptimer_i,
  output logic               halted_o,
  output logic               timeout_o,
  input  logic               timer_en_i,
  input  logic               timer_clr_i,
  output logic [TIMER_W-1:0] timer_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReq    = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;
  localparam logic [1:0] StResume = 2'd3;

  localparam logic [7:0] CntLast = 8'(REQ_TIMEOUT - 1);
  localparam logic [7:0] CntMax  = 8'hFF;

  logic [1:0]         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               halt_q;
  logic               halt_event;
  logic               debug_req_q;
  logic               halted_q;
  logic               timeout_q, timeout_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  // halt_q is updated in every state, so edges seen outside IDLE are dropped, not queued.
  assign halt_event = halt_req_i & ~halt_q;

  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (stoptimer_i) begin
          state_d = StHalted;
        end else if (halt_event) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (stoptimer_i) begin
          state_d = StHalted;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      StHalted: begin
        // Core leaving debug on its own wins over a pending resume request.
        if (!stoptimer_i) begin
          state_d = StIdle;
        end else if (resume_req_i) begin
          state_d = StResume;
        end
      end
      StResume: begin
        if (!stoptimer_i) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          state_d   = StHalted;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == StReq) || (state_q == StResume))) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 8'd1;
    end
  end

  // Uses raw stoptimer_i so the timer also freezes on debug entry we did not request.
  always_comb begin
    timer_d = timer_q;
    if (timer_clr_i) begin
      timer_d = '0;
    end else if (timer_en_i && !stoptimer_i) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      halt_q      <= 1'b0;
      debug_req_q <= 1'b0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      halt_q      <= halt_req_i;
      debug_req_q <= (state_q == StReq);
      halted_q    <= (state_q == StHalted) || (state_q == StResume);
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
    end
  end

  assign debug_req_o = debug_req_q;
  assign halted_o    = halted_q;
  assign timeout_o   = timeout_q;
  assign timer_o     = timer_q;

endmodule

// File: tb/tb_cvmcu_dbg_req_ctrl.sv
// Bench for cvmcu_dbg_req_ctrl: reset, vector table, directed corner cases and a random run
// against a mode/age reference model.
module tb_cvmcu_dbg_req_ctrl;

  localparam int TW   = 4;
  localparam int TOUT = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          halt_req_i, resume_req_i, stoptimer_i, timer_en_i, timer_clr_i;
  logic          debug_req_o, halted_o, timeout_o;
  logic [TW-1:0] timer_o;

  always #5 clk_i = ~clk_i;

  cvmcu_dbg_req_ctrl #(
    .TIMER_W    (TW),
    .REQ_TIMEOUT(TOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .halt_req_i  (halt_req_i),
    .resume_req_i(resume_req_i),
    .debug_req_o (debug_req_o),
    .stoptimer_i (stoptimer_i),
    .halted_o    (halted_o),
    .timeout_o   (timeout_o),
    .timer_en_i  (timer_en_i),
    .timer_clr_i (timer_clr_i),
    .timer_o     (timer_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: which mode the controller is in and how many cycles it has spent there.
  typedef enum int {MIdle, MReq, MHalted, MResume} mode_e;
  mode_e m_mode;
  int    m_age;
  bit    m_hprev;
  int    m_timer;
  bit    e_dbg, e_hal, e_to;

  task automatic model_reset();
    m_mode  = MIdle;
    m_age   = 0;
    m_hprev = 0;
    m_timer = 0;
    e_dbg   = 0;
    e_hal   = 0;
    e_to    = 0;
  endtask

  task automatic model_step();
    mode_e nm;
    bit    rise, to;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    rise = halt_req_i && !m_hprev;
    nm   = m_mode;
    to   = 0;
    case (m_mode)
      MIdle:   if (stoptimer_i) nm = MHalted; else if (rise) nm = MReq;
      MReq: begin
        if (stoptimer_i) nm = MHalted;
        else if (m_age == TOUT - 1) begin nm = MIdle; to = 1; end
      end
      MHalted: if (!stoptimer_i) nm = MIdle; else if (resume_req_i) nm = MResume;
      MResume: begin
        if (!stoptimer_i) nm = MIdle;
        else if (m_age == TOUT - 1) begin nm = MHalted; to = 1; end
      end
      default: nm = MIdle;
    endcase
    // Status outputs report the mode held during the cycle just ended.
    e_dbg = (m_mode == MReq);
    e_hal = (m_mode == MHalted) || (m_mode == MResume);
    e_to  = to;
    if (timer_clr_i) m_timer = 0;
    else if (timer_en_i && !stoptimer_i) m_timer = (m_timer + 1) % (1 << TW);
    m_age   = (nm == m_mode) ? m_age + 1 : 0;
    m_mode  = nm;
    m_hprev = halt_req_i;
  endtask

  task automatic drive(input bit h, input bit r, input bit s, input bit e, input bit c);
    halt_req_i   = h;
    resume_req_i = r;
    stoptimer_i  = s;
    timer_en_i   = e;
    timer_clr_i  = c;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    check("model", 32'({debug_req_o, halted_o, timeout_o, timer_o}),
          32'({e_dbg, e_hal, e_to, 4'(m_timer)}));
  endtask

  task automatic async_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst", 32'({debug_req_o, halted_o, timeout_o, timer_o}), 32'd0);
    model_reset();
    tick();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    bit       h, r, s, e, c;
    bit       dbg, hal, to;
    bit [3:0] tmr;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int dbg_cnt, to_cnt;
    //           h  r  s  e  c  dbg hal to tmr
    vecs[0]  = '{0, 0, 0, 1, 0, 0, 0, 0, 4'd1};
    vecs[1]  = '{1, 0, 0, 1, 0, 0, 0, 0, 4'd2};
    vecs[2]  = '{1, 0, 0, 1, 0, 1, 0, 0, 4'd3};
    vecs[3]  = '{1, 0, 0, 1, 0, 1, 0, 0, 4'd4};
    vecs[4]  = '{1, 0, 1, 1, 0, 1, 0, 0, 4'd4};
    vecs[5]  = '{1, 0, 1, 1, 0, 0, 1, 0, 4'd4};
    vecs[6]  = '{0, 1, 1, 1, 0, 0, 1, 0, 4'd4};
    vecs[7]  = '{0, 0, 1, 1, 0, 0, 1, 0, 4'd4};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, 1, 0, 4'd5};
    vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 4'd6};
    vecs[10] = '{0, 0, 0, 1, 1, 0, 0, 0, 4'd0};
    vecs[11] = '{0, 0, 1, 1, 0, 0, 0, 0, 4'd0};
    vecs[12] = '{0, 0, 1, 1, 0, 0, 1, 0, 4'd0};
    vecs[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 4'd1};
    vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 0, 4'd2};

    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) tick();
    check("reset_state", 32'({debug_req_o, halted_o, timeout_o, timer_o}), 32'd0);
    rst_ni = 1'b1;

    // Nominal halt, resume, clear and unrequested debug entry.
    foreach (vecs[i]) begin
      drive(vecs[i].h, vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].c);
      tick();
      check($sformatf("vec%0d", i), 32'({debug_req_o, halted_o, timeout_o, timer_o}),
            32'({vecs[i].dbg, vecs[i].hal, vecs[i].to, vecs[i].tmr}));
    end

    // Handshake timeout with halt held high: one request window, one pulse, no retrigger.
    drive(1, 0, 0, 0, 0);
    tick();
    dbg_cnt = 0;
    to_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dbg_cnt += int'(debug_req_o);
      to_cnt  += int'(timeout_o);
    end
    check("timeout_req_cycles", 32'(dbg_cnt), 32'(TOUT));
    check("timeout_pulses", 32'(to_cnt), 32'd1);

    // Timer freeze while stopped, wrap from all-ones, clear beats enable.
    drive(1, 0, 0, 1, 1);
    tick();
    check("timer_clr", 32'(timer_o), 32'd0);
    drive(1, 0, 0, 1, 0);
    repeat (3) tick();
    check("timer_count", 32'(timer_o), 32'd3);
    drive(1, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("timer_freeze", 32'(timer_o), 32'd3);
    end
    drive(1, 0, 0, 1, 0);
    repeat (12) tick();
    check("timer_max", 32'(timer_o), 32'd15);
    tick();
    check("timer_wrap0", 32'(timer_o), 32'd0);
    tick();
    check("timer_wrap1", 32'(timer_o), 32'd1);
    drive(1, 0, 0, 1, 1);
    tick();
    check("timer_clr_en", 32'(timer_o), 32'd0);

    // Reset in the middle of a request, released with halt already high.
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0);
    tick();
    tick();
    check("req_before_rst", 32'(debug_req_o), 32'd1);
    async_reset();
    tick();
    check("req_lag_after_rst", 32'(debug_req_o), 32'd0);
    tick();
    check("req_after_rst", 32'(debug_req_o), 32'd1);

    // Random traffic with sticky stoptimer and bursty halt/resume.
    for (int i = 0; i < 3000; i++) begin
      bit h, r, s, e, c;
      h = ($urandom_range(0, 3) == 0) ? !halt_req_i : halt_req_i;
      s = ($urandom_range(0, 9) == 0) ? !stoptimer_i : stoptimer_i;
      r = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 15) == 0);
      drive(h, r, s, e, c);
      if ($urandom_range(0, 299) == 0) async_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cvmcu_dbg_req_ctrl.md
CVMCU_DBG_REQ_CTRL -- requirements
Module: cvmcu_dbg_req_ctrl

Interface
REQ-001 The block SHALL have parameter TIMER_W, default 32, meaning the width of the debug-aware system timer.
REQ-002 The block SHALL have parameter REQ_TIMEOUT, default 255, meaning the handshake timeout in cycles; legal range is 1..255.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low. Ports are clk_i and rst_ni.
REQ-004 The block SHALL have the following ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- halt_req_i  in  1  halt request level from the debug module.
- resume_req_i  in  1  resume request level from the debug module.
- debug_req_o  out  1  drives the core debug_req_i.
- stoptimer_i  in  1  driven by the core stoptimer_o; high while the core is in debug mode.
- halted_o  out  1  core halted under controller supervision.
- timeout_o  out  1  one-cycle pulse on handshake timeout.
- timer_en_i  in  1  timer count enable.
- timer_clr_i  in  1  synchronous timer clear.
- timer_o  out  TIMER_W  system timer value.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 A halt event SHALL be a rising edge of halt_req_i, detected against a registered copy halt_q.
REQ-007 The FSM SHALL have four states: IDLE, REQ, HALTED and RESUME.
REQ-008 IDLE behaviour:
- If stoptimer_i=1, go to HALTED; this has priority over a halt event.
- Otherwise, a halt event goes to REQ.
- resume_req_i is ignored.
REQ-009 REQ behaviour:
- debug_req_o=1 for every cycle the FSM is in REQ.
- Cycle counter cnt starts at 0 on entry and increments each cycle.
- If stoptimer_i=1, go to HALTED.
- Else if cnt==REQ_TIMEOUT-1, go to IDLE and pulse timeout_o for one cycle.
REQ-010 Latency: a halt event sampled at edge N SHALL produce debug_req_o=1 from edge N+1.
REQ-011 debug_req_o SHALL fall at the edge after stoptimer_i is sampled high.
REQ-012 HALTED behaviour:
- halted_o=1 for every cycle the FSM is in HALTED.
- If stoptimer_i=0, go to IDLE; this covers a core that self-resumes and has priority.
- Else if resume_req_i=1, go to RESUME.
REQ-013 RESUME behaviour:
- halted_o=1 and cnt restarts at 0 on entry.
- If stoptimer_i=0, go to IDLE.
- Else if cnt==REQ_TIMEOUT-1, go to HALTED and pulse timeout_o for one cycle.
REQ-014 A held-high halt_req_i SHALL NOT retrigger REQ after a timeout; a new rising edge is required.
REQ-015 Halt events occurring in REQ, HALTED or RESUME SHALL be ignored and SHALL NOT be queued.
REQ-016 timer_o update priority:
- timer_clr_i=1: load 0.
- Else if timer_en_i=1 and stoptimer_i=0: increment by 1.
- Else: hold.
REQ-017 timer_o SHALL wrap from all-ones to 0 with no flag.
REQ-018 The timer SHALL use raw stoptimer_i regardless of FSM state, so it also freezes during debug entry not requested by this block.
REQ-019 cnt SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-020 On rst_ni=0, the block SHALL asynchronously set: state=IDLE, debug_req_o=0, halted_o=0, timeout_o=0, timer_o=0, cnt=0, halt_q=0.
REQ-021 Reset asserted in any state SHALL drop debug_req_o immediately, without waiting for a clock edge.
REQ-022 After reset release, a halt_req_i already high SHALL count as a rising edge on the first sampling edge, because halt_q=0.

Verification
REQ-023 Nominal halt: halt_req_i rises at edge 10 and stoptimer_i rises at edge 14 -> debug_req_o=1 over edges 11..14, 0 at 15; halted_o=1 from 15.
REQ-024 Timeout: with REQ_TIMEOUT=8, halt_req_i rises at edge 10 and is held, stoptimer_i stays 0 -> debug_req_o=1 for 8 cycles; timeout_o pulses once; FSM returns to IDLE; no retrigger occurs.
REQ-025 Resume: in HALTED, resume_req_i=1 and stoptimer_i falls 3 cycles later -> RESUME then IDLE; halted_o=0 one edge after stoptimer_i is sampled low.
REQ-026 Timer freeze and wrap:
- Stage 1: TIMER_W=4, timer_en_i=1, stoptimer_i=1 for 5 cycles -> timer_o holds its value.
- Stage 2: then stoptimer_i=0 from timer_o=15 -> 0 then 1.
- Stage 3: timer_clr_i together with timer_en_i -> 0.
REQ-027 Unrequested entry: in IDLE, stoptimer_i=1 with halt_req_i=0 -> HALTED next edge and debug_req_o stays 0.
REQ-028 Mid-operation reset: rst_ni=0 while in REQ -> debug_req_o=0 within the same cycle. After release with halt_req_i high -> REQ is re-entered on the first edge.
